// File: rtl/srst_sequencer_pkg.sv
// rtl/srst_sequencer_pkg.sv - shared types, widths and helpers for the synchronous-reset sequencer.
package srst_sequencer_pkg;

  localparam int COUNT_W = 8;
  localparam int TIMER_W = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GUARD  = 2'd2
  } state_e;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/srst_seq_timer.sv
// rtl/srst_seq_timer.sv - loadable down-counter with zero flag timing the ASSERT and GUARD phases.
module srst_seq_timer
  import srst_sequencer_pkg::*;
(
  input  logic               i_sclk,
  input  logic               i_arst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge i_sclk or posedge i_arst) begin
    if (i_arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/srst_sequencer.sv
// rtl/srst_sequencer.sv - request/ack driven synchronous reset pulse generator.
// Optional periodic auto trigger enabled by defining SRST_SEQUENCER_AUTO_EN.
module srst_sequencer
  import srst_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES  = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int PERIOD_W     = 4
) (
  input  logic               i_sclk,
  input  logic               i_arst,
  input  logic               i_req,
  output logic               o_ack,
  output logic               o_srst,
  output logic               o_busy,
  output logic [COUNT_W-1:0] o_count
);

  localparam logic [TIMER_W-1:0] HOLD_LD  = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GUARD_LD = TIMER_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic               arm_q, arm_d;
  logic               req_src_q, req_src_d;
  logic               cnt_src_q, cnt_src_d;
  logic               ack_q, ack_d;
  logic               srst_q, srst_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0] tmr_val;
  logic               req_trig, auto_trig;

  // A request seen in the ack cycle belongs to the sequence just served.
  assign req_trig = i_req && !ack_q;

`ifdef SRST_SEQUENCER_AUTO_EN
  logic [PERIOD_W-1:0] period_q, period_d;

  always_comb begin
    period_d = '0;
    if ((state_q == ST_IDLE) && (state_d == ST_IDLE)) begin
      period_d = period_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge i_sclk or posedge i_arst) begin
    if (i_arst) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end

  assign auto_trig = (state_q == ST_IDLE) && (period_q == '1);
`else
  assign auto_trig = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    req_src_d = req_src_q;
    cnt_src_d = cnt_src_q;
    ack_d     = 1'b0;
    count_d   = count_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_trig || auto_trig) begin
          state_d   = ST_ASSERT;
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LD;
          req_src_d = req_trig;
          cnt_src_d = 1'b1;
        end
      end
      ST_ASSERT: begin
        // Reset leaves the timer cleared; the first cycle afterwards arms it.
        if (arm_q) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
          arm_d    = 1'b0;
        end else if (tmr_zero) begin
          ack_d = req_src_q;
          if (cnt_src_q) begin
            count_d = sat_inc(count_q);
          end
          if (GUARD_CYCLES > 0) begin
            state_d  = ST_GUARD;
            tmr_load = 1'b1;
            tmr_val  = GUARD_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_GUARD: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign srst_d = (state_d == ST_ASSERT);

  always_ff @(posedge i_sclk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= ST_ASSERT;
      arm_q     <= 1'b1;
      req_src_q <= 1'b0;
      cnt_src_q <= 1'b0;
      ack_q     <= 1'b0;
      srst_q    <= 1'b1;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      req_src_q <= req_src_d;
      cnt_src_q <= cnt_src_d;
      ack_q     <= ack_d;
      srst_q    <= srst_d;
      count_q   <= count_d;
    end
  end

  srst_seq_timer u_timer (
    .i_sclk     (i_sclk),
    .i_arst     (i_arst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .i_dec      (tmr_dec),
    .o_zero     (tmr_zero)
  );

  assign o_ack   = ack_q;
  assign o_srst  = srst_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_count = count_q;

endmodule

// File: tb/tb_srst_sequencer.sv
// tb/tb_srst_sequencer.sv - directed vector bench for srst_sequencer (HOLD=4, GUARD=2 and GUARD=0 instances).
module tb_srst_sequencer;

  logic       clk = 1'b0;
  logic       arst, req, arst0, req0;
  logic       srst, ack, busy, srst0, ack0, busy0;
  logic [7:0] count, count0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  srst_sequencer #(.HOLD_CYCLES(4), .GUARD_CYCLES(2), .PERIOD_W(4)) u_dut (
    .i_sclk(clk), .i_arst(arst), .i_req(req),
    .o_ack(ack), .o_srst(srst), .o_busy(busy), .o_count(count)
  );

  srst_sequencer #(.HOLD_CYCLES(4), .GUARD_CYCLES(0), .PERIOD_W(4)) u_dut0 (
    .i_sclk(clk), .i_arst(arst0), .i_req(req0),
    .o_ack(ack0), .o_srst(srst0), .o_busy(busy0), .o_count(count0)
  );

  typedef struct {
    logic       req;
    logic       arst;
    logic       srst;
    logic       ack;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack0(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ack0) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [19:0] ackv, busyv, eack, ebusy;
    logic [11:0] sv, av, esv, eav;
    bit          got;
    int          idle;
    int          exp_cnt;

    // release, then idle, then one request dropped on ack
    for (int i = 0; i < 4; i++)   vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    for (int i = 4; i < 6; i++)   vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    for (int i = 6; i < 8; i++)   vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    for (int i = 8; i < 12; i++)  vecs[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    for (int i = 14; i < 16; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

    arst = 1'b1; arst0 = 1'b1; req = 1'b0; req0 = 1'b0;
    repeat (3) step();
    check("reset_state", {srst, ack, busy, count}, {1'b1, 1'b0, 1'b1, 8'd0});
    check("reset_state_g0", {srst0, ack0, busy0, count0}, {1'b1, 1'b0, 1'b1, 8'd0});
    arst = 1'b0; arst0 = 1'b0;

    for (int i = 0; i < 16; i++) begin
      req  = vecs[i].req;
      arst = vecs[i].arst;
      step();
      check($sformatf("vec%0d srst_ack_busy_cnt", i), {srst, ack, busy, count},
            {vecs[i].srst, vecs[i].ack, vecs[i].busy, vecs[i].cnt});
    end

    // request held 20 cycles: back-to-back sequences with one idle cycle between
    req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      ackv[k-1]  = ack;
      busyv[k-1] = busy;
      eack[k-1]  = (k == 5) || (k == 12) || (k == 19);
      ebusy[k-1] = !((k == 7) || (k == 14));
    end
    req = 1'b0;
    check("held_req ack pattern", 32'(ackv), 32'(eack));
    check("held_req busy pattern", 32'(busyv), 32'(ebusy));
    check("held_req count", 32'(count), 32'd4);
    step();
    check("held_req idle after", 32'(busy), 32'd0);

    // reset during 2nd ASSERT cycle of a request sequence
    req = 1'b1;
    step();
    step();
    check("abort in assert", 32'(srst), 32'd1);
    arst = 1'b1;
    #1;
    check("abort reset outputs", {srst, ack, busy, count}, {1'b1, 1'b0, 1'b1, 8'd0});
    step();
    step();
    arst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      sv[k-1]  = srst;
      av[k-1]  = ack;
      esv[k-1] = (k <= 4) || ((k >= 8) && (k <= 11));
      eav[k-1] = (k == 12);
      if (k == 11) check("post_reset count before ack", 32'(count), 32'd0);
      if (k == 12) check("post_reset count at ack", 32'(count), 32'd1);
    end
    req = 1'b0;
    check("post_reset srst pattern", 32'(sv), 32'(esv));
    check("post_reset ack pattern", 32'(av), 32'(eav));
    repeat (2) step();
    check("post_reset idle", 32'(busy), 32'd0);

`ifdef SRST_SEQUENCER_AUTO_EN
    idle = 1;
    for (int i = 0; i < 40 && !busy; i++) begin
      step();
      if (!busy) idle++;
    end
    check("auto idle cycles", 32'(idle), 32'd16);
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack) got = 1'b1;
    end
    check("auto no ack", 32'(got), 32'd0);
    check("auto count", 32'(count), 32'd2);
    check("auto back to idle", 32'(busy), 32'd0);
    idle = 1;
    for (int i = 0; i < 40 && idle < 16; i++) begin
      step();
      if (!busy) idle++;
    end
    req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack) begin
        got = 1'b1;
        req = 1'b0;
      end
    end
    req = 1'b0;
    check("coincide ack", 32'(got), 32'd1);
    check("coincide count", 32'(count), 32'd3);
`endif

    // GUARD_CYCLES=0 instance: 300 sequences, count saturates
    arst0 = 1'b1;
    step();
    arst0 = 1'b0;
    req0  = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      wait_ack0(got);
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL g0 ack timeout: sequence %0d got no ack, required ack within 30 cycles", n);
        break;
      end
      exp_cnt = (n > 255) ? 255 : n;
      check($sformatf("g0 seq%0d busy_count at ack", n), {busy0, count0}, {1'b0, 8'(exp_cnt)});
      if (n <= 2) begin
        step();
        check($sformatf("g0 seq%0d req ignored in ack cycle", n), {busy0, srst0, ack0}, 3'b000);
      end
    end
    req0 = 1'b0;
    repeat (8) step();
    check("g0 final count no wrap", 32'(count0), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
